// File: rtl/collenda_switch_input.sv
// collenda_switch_input: Avalon-MM switch/button input port.
// Each input bit is synchronised, debounced and edge-detected. Selected edges
// set sticky capture bits that software clears by writing 1s, and a maskable
// level interrupt is raised from them. Reads have one cycle of registered latency.
module collenda_switch_input #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_MASK    = 2'd1,
      REG_CAPTURE = 2'd2,
      REG_RAW     = 2'd3
   } reg_addr_t;

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] stable;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;

   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] capture_next;
   logic [31:0]      read_mux;
   logic             wr_en;
   logic             unused_writedata;

   assign wr_en = chipselect && !write_n;

   // Only the low WIDTH bits of writedata carry register state.
   assign unused_writedata = ^writedata;

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

   // Per-bit accept strobe and the capture set bits it produces.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch
      // can be inferred on any path.
      accept   = '0;
      edge_set = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
         case (EDGE_TYPE)
            0:       edge_set[i] = accept[i] &&  s2[i];
            1:       edge_set[i] = accept[i] && !s2[i];
            default: edge_set[i] = accept[i];
         endcase
      end
   end

   // Debounce: a bit must differ from its stable value for DEBOUNCE_CYCLES clocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= '0;
         // NOTE: the counter array is a handful of flops, not a RAM, so it is
         // reset; a partial count must never survive reset.
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Next values of the software-visible registers; a new edge beats a clear.
   always_comb begin
      mask_next = mask;
      clr       = '0;
      if (wr_en && reg_addr_t'(address) == REG_MASK)    mask_next = writedata[WIDTH-1:0];
      if (wr_en && reg_addr_t'(address) == REG_CAPTURE) clr       = writedata[WIDTH-1:0];
      capture_next = (capture & ~clr) | edge_set;
   end

   // Read mux; unused upper bits read as zero.
   always_comb begin
      read_mux = '0;
      case (reg_addr_t'(address))
         REG_DATA:    read_mux[WIDTH-1:0] = stable;
         REG_MASK:    read_mux[WIDTH-1:0] = mask;
         REG_CAPTURE: read_mux[WIDTH-1:0] = capture;
         REG_RAW:     read_mux[WIDTH-1:0] = s2;
         default:     read_mux = '0;
      endcase
   end

   // Register mask, capture, read data and a glitch-free interrupt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask     <= '0;
         capture  <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         mask     <= mask_next;
         capture  <= capture_next;
         readdata <= read_mux;
         irq      <= |(capture_next & mask_next);
      end
   end

endmodule

// File: tb/tb_collenda_switch_input.sv
// Directed testbench for collenda_switch_input: reset capture, glitch rejection,
// debounce boundary, interrupt/clear, mask gating, set/clear collision,
// edge-type selection and the single-cycle debounce case.
module tb_collenda_switch_input;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd0, rd1, rd2, rd3;
   logic        irq0, irq1, irq2, irq3;

   int checks   = 0;
   int failures = 0;
   logic seen;

   always #5 clk = ~clk;

   // Rising-edge capture, D=16 (main device under test).
   collenda_switch_input #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   // Falling-edge capture.
   collenda_switch_input #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd1), .irq(irq1));

   // Any-edge capture.
   collenda_switch_input #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd2), .irq(irq2));

   // Single-cycle debounce.
   collenda_switch_input #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) dut3 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd3), .irq(irq3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; drive and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present an address for one edge; readdata is valid on return.
   task automatic rd(input logic [1:0] a);
      address = a;
      tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      in_port    = 4'b1010;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      #1;
      check("reset_readdata", rd0, 32'h0);
      check("reset_irq", {31'd0, irq0}, 32'h0);
      ticks(2);
      reset = 1'b0;
      ticks(20);

      // Inputs held high through reset appear as data and as rising captures.
      rd(2'd0); check("data_after_reset", rd0, 32'hA);
      rd(2'd2); check("capture_after_reset", rd0, 32'hA);
      rd(2'd3); check("raw_after_reset", rd0, 32'hA);
      rd(2'd1); check("mask_after_reset", rd0, 32'h0);
      check("irq_masked_off", {31'd0, irq0}, 32'h0);

      wr(2'd2, 32'hF);
      rd(2'd2); check("capture_cleared", rd0, 32'h0);
      wr(2'd1, 32'h1);

      // A 10-clock glitch on bit 0 must never be accepted.
      address = 2'd0;
      seen    = 1'b0;
      in_port = 4'b1011;
      for (int i = 0; i < 10; i++) begin tick(); seen |= irq0 | rd0[0]; end
      in_port = 4'b1010;
      for (int i = 0; i < 30; i++) begin tick(); seen |= irq0 | rd0[0]; end
      check("glitch_no_effect", {31'd0, seen}, 32'h0);
      rd(2'd2); check("glitch_capture", rd0, 32'h0);

      // Held pulse: stable and capture change exactly at edge 18.
      address = 2'd0;
      in_port = 4'b1011;
      ticks(17);
      check("edge17_irq", {31'd0, irq0}, 32'h0);
      check("edge17_data", rd0, 32'hA);
      tick();
      check("edge18_irq", {31'd0, irq0}, 32'h1);
      tick();
      check("edge19_data", rd0, 32'hB);
      rd(2'd2); check("capture_bit0", rd0, 32'h1);
      wr(2'd2, 32'h1);
      check("irq_after_clear", {31'd0, irq0}, 32'h0);
      rd(2'd2); check("capture_after_clear", rd0, 32'h0);

      // Mask gating: capture=0x3 with mask 0 keeps irq low.
      wr(2'd1, 32'h0);
      in_port = 4'b1000;
      ticks(20);
      in_port = 4'b1011;
      ticks(20);
      check("irq_mask_zero", {31'd0, irq0}, 32'h0);
      rd(2'd2); check("capture_two_bits", rd0, 32'h3);
      wr(2'd1, 32'h2);
      check("irq_mask_two", {31'd0, irq0}, 32'h1);
      rd(2'd1); check("mask_readback", rd0, 32'h2);

      // Set/clear collision on bit 1.
      in_port = 4'b1001;
      ticks(20);
      rd(2'd2); check("falling_ignored", rd0, 32'h3);
      in_port = 4'b1011;
      ticks(17);
      wr(2'd2, 32'h2);
      rd(2'd2); check("collision_set_wins", rd0, 32'h3);
      check("collision_irq", {31'd0, irq0}, 32'h1);
      wr(2'd2, 32'h2);
      rd(2'd2); check("plain_clear_bit1", rd0, 32'h1);
      check("irq_bit1_cleared", {31'd0, irq0}, 32'h0);

      // Reset mid-operation clears captures and irq.
      wr(2'd1, 32'h3);
      check("irq_before_reset", {31'd0, irq0}, 32'h1);
      in_port = 4'b0000;
      reset   = 1'b1;
      #1;
      check("irq_async_reset", {31'd0, irq0}, 32'h0);
      check("readdata_async_reset", rd0, 32'h0);
      tick();
      reset = 1'b0;
      ticks(20);

      // Edge-type selection, plus single-cycle debounce timing on dut3.
      address = 2'd0;
      in_port = 4'b0100;
      ticks(3);
      check("d1_edge3_data", rd3, 32'h0);
      tick();
      check("d1_edge4_data", rd3, 32'h4);
      ticks(16);
      rd(2'd2);
      check("rise_edge0", rd0, 32'h4);
      check("rise_edge1", rd1, 32'h0);
      check("rise_edge2", rd2, 32'h4);
      wr(2'd2, 32'h4);
      in_port = 4'b0000;
      ticks(20);
      rd(2'd2);
      check("fall_edge0", rd0, 32'h0);
      check("fall_edge1", rd1, 32'h4);
      check("fall_edge2", rd2, 32'h4);
      check("fall_d1", rd3, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/collenda_switch_input.md
# collenda_switch_input

Parametrised Avalon-MM input port for board switches and push-buttons. It synchronises and debounces `WIDTH` asynchronous inputs and latches selected edges into a sticky edge-capture register. A maskable interrupt is raised from that register. It is the next generation of the plain switch PIO and is read by the Nios II over the same slave bus with one-cycle registered read latency.

## Interface
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 16: consecutive clocks a synchronised bit must differ from its stable value before it is accepted; ≥1. Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
- `EDGE_TYPE`, 0: edge to capture; 0 = rising, 1 = falling, 2 = any.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: raw asynchronous switch inputs.
- `readdata` out 32: registered read data.
- `irq` out 1: interrupt request, active-high, level.

## Operation
- Register map. Bits [31:WIDTH] always read 0.
  - 0: debounced data, read-only.
  - 1: irq mask, read/write.
  - 2: edge capture; read, and write-1-to-clear.
  - 3: raw synchronised input (second synchroniser stage), read-only.
- Synchroniser: two flops per bit, s1 <= in_port, s2 <= s1.
- Debounce, per bit, every clock:
  - if s2 == stable: cnt <= 0.
  - otherwise, if cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES clocks resets the count and is never accepted.
- Edge detect: the edge capture bit i sets on the same edge that stable[i] changes, if that change matches `EDGE_TYPE`.
- Edge capture bits stay set until cleared by software.
- Write is `chipselect` && !`write_n`.
  - Address 1 loads mask <= writedata[WIDTH-1:0].
  - Address 2 clears the capture bits where writedata is 1.
  - Writes to addresses 0 and 3 are ignored.
- Set/clear collision: if a new edge and a clear hit the same bit on the same clock, set wins and the bit stays 1.
- `irq` = |(capture & mask). It is formed from registers only, so no glitches on the output.
- Read: `readdata` is registered every clock from the `address` mux, independent of `chipselect`.

## Timing
- Reset, asynchronous: s1, s2, stable, cnt, mask, capture, `readdata` and `irq` are all 0.
  - An input held high through reset is accepted as a rising edge DEBOUNCE_CYCLES+2 clocks after reset release.
- Input latency:
  - in_port changes before edge 1 and holds; s2 shows the new value after edge 2.
  - stable changes at edge 2+DEBOUNCE_CYCLES.
  - The capture bit and `irq` are visible after that same edge.
- Read latency: `address` presented at edge n gives `readdata` valid after edge n, for one cycle.
- Write latency:
  - Mask and capture update at the write edge.
  - `irq` reflects the write after that edge.
  - A read of the same register starting the next cycle returns the new value.
- Reset mid-debounce discards the partial count. Reset mid-operation clears pending captures and `irq`.
- `DEBOUNCE_CYCLES` = 1: a bit is accepted one clock after s2 differs.

## Test plan
- Reset and data read:
  - Assert `reset` with `in_port`=4'b1010, release, hold 20 clocks with D=16.
  - Read address 0 → 0x0000000A.
  - Read address 2 → 0x0000000A (rising captures).
  - Read address 3 → 0x0000000A.
- Glitch rejection:
  - With D=16, pulse `in_port`[0] high for 10 clocks.
  - Address 0 stays 0, capture stays 0, `irq` stays 0.
  - A pulse held 20 clocks sets data bit 0 exactly at edge 18 after the change.
- Interrupt and clear:
  - Mask=0x1, rising edge on bit 0 → `irq`=1.
  - Write 0x1 to address 2 → `irq`=0 after the write edge; capture reads 0.
- Mask gating: mask=0x0 with capture=0x3 → `irq`=0. Then write mask 0x2 → `irq`=1.
- Set/clear collision: time a debounced edge on bit 1 to the same clock as a write of 0x2 to address 2 → capture bit 1 reads 1.
- EDGE_TYPE:
  - With `EDGE_TYPE`=1, a rise on bit 2 leaves capture at 0.
  - The following fall sets capture to 0x4.
  - With `EDGE_TYPE`=2, both edges set the bit.
